apb2axi_apb_master: RTL
=======================

// Module: apb2axi_apb_master
// PURPOSE
//  APB initiator (requester side of the apb2axi gateway register interface).
//  - Converts a valid/ready request stream into one APB3 SETUP/ACCESS transfer at a time.
//  - Returns a response record: rdata, slverr, timeout.
//  - Drives the gateway register slave from the SoC-side bus bridge, and drives it in block-level benches.
// PARAMETERS
//  APB_ADDR_W      apb2axi_pkg::APB_ADDR_W  paddr width
//  APB_DATA_W      apb2axi_pkg::APB_DATA_W  pwdata/prdata width
//  TIMEOUT_CYCLES  256                      ACCESS cycles with pready low before abort (APB_MASTER_TIMEOUT_EN only)
// PORTS
//  pclk         in   1           clock
//  preset       in   1           asynchronous reset, active-high
//  req_valid    in   1           request present
//  req_ready    out  1           request accepted when req_valid & req_ready at posedge
//  req_write    in   1           1=write, 0=read
//  req_addr     in   APB_ADDR_W  target address
//  req_wdata    in   APB_DATA_W  write data (ignored for reads)
//  rsp_valid    out  1           response present; held until rsp_ready
//  rsp_ready    in   1           response consumed
//  rsp_rdata    out  APB_DATA_W  captured prdata (0 for writes and timeouts)
//  rsp_err      out  1           pslverr sampled at completion, or timeout
//  rsp_timeout  out  1           transfer aborted by watchdog
//  busy         out  1           state != IDLE
//  psel         out  1           APB select
//  penable      out  1           APB enable
//  pwrite       out  1           APB direction
//  paddr        out  APB_ADDR_W  APB address
//  pwdata       out  APB_DATA_W  APB write data; 0 on reads
//  pready       in   1           slave ready
//  pslverr      in   1           slave error
//  prdata       in   APB_DATA_W  slave read data
// BEHAVIOUR
//  - All APB and rsp outputs are registered.
//  - While preset is high, every output is 0, including req_ready. FSM goes to IDLE.
//  - FSM states IDLE, SETUP, ACCESS, RESP.
//  - req_ready = (IDLE) | (RESP & rsp_ready). It is combinational from state and rsp_ready only.
//  - IDLE: on accept, latch write/addr/wdata into paddr/pwrite/pwdata and go to SETUP.
//    SETUP: psel=1, penable=0.
//  - SETUP -> ACCESS unconditionally (one cycle). In ACCESS, psel=1 and penable=1.
//  - paddr, pwrite and pwdata are stable from SETUP through the last ACCESS cycle.
//  - ACCESS with pready=1: capture prdata (reads only) and pslverr. psel and penable go 0 at that edge. Go to RESP.
//  - ACCESS with pready=0: hold all APB outputs (wait state).
//  - RESP: rsp_valid=1 and all rsp_* fields stable until rsp_ready.
//    - rsp_ready & !req_valid -> IDLE.
//    - rsp_ready & req_valid -> accept the new request and go directly to SETUP (no idle bubble).
//  - Latency: accept at edge N -> SETUP cycle N+1 -> ACCESS N+2 -> rsp_valid from N+3 (zero wait states).
//    Each wait state adds 1 cycle.
//  - psel is never asserted in IDLE or RESP. penable is never 1 without psel. Never more than one outstanding transfer.
//  - Reset mid-transfer: psel and penable drop asynchronously. The latched request and any pending response are discarded.
//  - busy = 1 in SETUP, ACCESS and RESP.
// CONFIGURATION
//  Macro APB_MASTER_TIMEOUT_EN.
//  - Defined:
//    - Counter of width $clog2(TIMEOUT_CYCLES+1) clears on entry to ACCESS and increments each ACCESS cycle with pready=0.
//    - When it reaches TIMEOUT_CYCLES with pready still 0: psel and penable go 0, go to RESP with rsp_err=1, rsp_timeout=1, rsp_rdata=0.
//    - pready=1 in the same cycle as terminal count completes normally (no timeout).
//  - Undefined: no counter. ACCESS waits indefinitely, rsp_timeout is tied 0, TIMEOUT_CYCLES is unused.
// TESTING
//  - Write: req addr=0x08, wdata=0x8000_0307, pready=1 -> psel N+1, penable N+2, rsp_valid N+3, rsp_err=0, pwdata=0x8000_0307 in SETUP/ACCESS.
//  - Read with waits: addr=0x0C, pready low for 4 ACCESS cycles, prdata=0x0000_8123 -> ACCESS lasts 5 cycles, paddr stable, rsp_rdata=0x0000_8123 at N+7.
//  - Error: read addr=0x10, pslverr=1 with pready -> rsp_err=1, rsp_timeout=0.
//  - Back-to-back: rsp_ready=1 and req_valid=1 in RESP -> next SETUP the following cycle; rsp held 3 cycles when rsp_ready=0 first.
//  - Timeout (macro on, TIMEOUT_CYCLES=8): pready stuck 0 -> abort after 8 wait cycles; rsp_err=1, rsp_timeout=1, rsp_rdata=0. Macro off -> still in ACCESS at 100 cycles.
//  - Reset: assert preset in the 2nd ACCESS cycle -> psel/penable 0 before the next edge; after release req_ready=1, rsp_valid=0.

Source files
------------

// File: rtl/apb2axi_apb_master.sv
// APB3 initiator: turns a valid/ready request stream into one SETUP/ACCESS transfer at a time.
// Optional ACCESS watchdog enabled by defining APB_MASTER_TIMEOUT_EN.
module apb2axi_apb_master #(
    parameter int APB_ADDR_W     = 32,
    parameter int APB_DATA_W     = 32,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                  pclk,
    input  logic                  preset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [APB_ADDR_W-1:0] req_addr,
    input  logic [APB_DATA_W-1:0] req_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [APB_DATA_W-1:0] rsp_rdata,
    output logic                  rsp_err,
    output logic                  rsp_timeout,
    output logic                  busy,
    output logic                  psel,
    output logic                  penable,
    output logic                  pwrite,
    output logic [APB_ADDR_W-1:0] paddr,
    output logic [APB_DATA_W-1:0] pwdata,
    input  logic                  pready,
    input  logic                  pslverr,
    input  logic [APB_DATA_W-1:0] prdata
);

    typedef enum logic [1:0] {ST_IDLE, ST_SETUP, ST_ACCESS, ST_RESP} state_t;

    state_t                state_q;
    logic                  psel_q, penable_q, pwrite_q;
    logic [APB_ADDR_W-1:0] paddr_q;
    logic [APB_DATA_W-1:0] pwdata_q;
    logic                  rsp_valid_q, rsp_err_q, rsp_timeout_q;
    logic [APB_DATA_W-1:0] rsp_rdata_q;
    logic                  timeout_hit;

`ifdef APB_MASTER_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] wait_cnt_q;

    assign timeout_hit = (wait_cnt_q == CNT_W'(TIMEOUT_CYCLES));

    // Cleared during SETUP so it reads zero on the first ACCESS cycle.
    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            wait_cnt_q <= '0;
        end else if (state_q == ST_SETUP) begin
            wait_cnt_q <= '0;
        end else if (state_q == ST_ACCESS && !pready && !timeout_hit) begin
            wait_cnt_q <= wait_cnt_q + 1'b1;
        end
    end
`else
    // Never true: without the watchdog ACCESS waits for pready indefinitely.
    assign timeout_hit = (TIMEOUT_CYCLES < 0);
`endif

    assign req_ready = !preset && ((state_q == ST_IDLE) || (state_q == ST_RESP && rsp_ready));

    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            state_q       <= ST_IDLE;
            psel_q        <= 1'b0;
            penable_q     <= 1'b0;
            pwrite_q      <= 1'b0;
            paddr_q       <= '0;
            pwdata_q      <= '0;
            rsp_valid_q   <= 1'b0;
            rsp_err_q     <= 1'b0;
            rsp_timeout_q <= 1'b0;
            rsp_rdata_q   <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (req_valid) begin
                        pwrite_q  <= req_write;
                        paddr_q   <= req_addr;
                        pwdata_q  <= req_write ? req_wdata : '0;
                        psel_q    <= 1'b1;
                        penable_q <= 1'b0;
                        state_q   <= ST_SETUP;
                    end
                end
                ST_SETUP: begin
                    penable_q <= 1'b1;
                    state_q   <= ST_ACCESS;
                end
                ST_ACCESS: begin
                    if (pready) begin
                        psel_q        <= 1'b0;
                        penable_q     <= 1'b0;
                        rsp_valid_q   <= 1'b1;
                        rsp_rdata_q   <= pwrite_q ? '0 : prdata;
                        rsp_err_q     <= pslverr;
                        rsp_timeout_q <= 1'b0;
                        state_q       <= ST_RESP;
                    end else if (timeout_hit) begin
                        psel_q        <= 1'b0;
                        penable_q     <= 1'b0;
                        rsp_valid_q   <= 1'b1;
                        rsp_rdata_q   <= '0;
                        rsp_err_q     <= 1'b1;
                        rsp_timeout_q <= 1'b1;
                        state_q       <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        // Chained request skips IDLE and starts SETUP right away.
                        if (req_valid) begin
                            pwrite_q  <= req_write;
                            paddr_q   <= req_addr;
                            pwdata_q  <= req_write ? req_wdata : '0;
                            psel_q    <= 1'b1;
                            penable_q <= 1'b0;
                            state_q   <= ST_SETUP;
                        end else begin
                            state_q   <= ST_IDLE;
                        end
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign busy        = (state_q != ST_IDLE);
    assign psel        = psel_q;
    assign penable     = penable_q;
    assign pwrite      = pwrite_q;
    assign paddr       = paddr_q;
    assign pwdata      = pwdata_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_rdata   = rsp_rdata_q;
    assign rsp_err     = rsp_err_q;
    assign rsp_timeout = rsp_timeout_q;

endmodule
